// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC default, NOP encoding and PC arithmetic.
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INS          = 32'h0000_0000;
  localparam logic [31:0] INS_BYTES        = 32'd4;

  // Sequential PC; 32-bit wrap-around is intended (FFFF_FFFC + 4 = 0).
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + INS_BYTES;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load; otherwise the contents hold.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] ins,
  input  logic [31:0] pc4,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  // A bubble leaves id_pc4 untouched so downstream still sees the last real PC+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ins   <= 32'h0000_0000;
      id_pc4   <= 32'h0000_0000;
      id_valid <= 1'b0;
    end else if (bubble) begin
      id_ins   <= NOP_INS;
      id_valid <= 1'b0;
    end else if (load) begin
      id_ins   <= ins;
      id_pc4   <= pc4;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request FSM (FETCH/HOLD/DRAIN), one-word hold buffer and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 PcWrite,
  input  logic                 IF_IDWrite,
  input  logic                 Stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          IF_ID_ins,
  output logic [31:0]          IF_ID_pc4,
  output logic                 IF_ID_valid,
  output logic                 fetch_busy
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_r;
  state_e      state_nx_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nx_s;
  logic [31:0] hold_buf_r;
  logic [31:0] hold_buf_nx_s;

  logic        consume_s;
  logic        avail_s;
  logic [31:0] avail_ins_s;
  logic        ifid_load_s;
  logic        ifid_bubble_s;

  assign consume_s = PcWrite & IF_IDWrite & ~Stall;

  // State, PC and hold-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      hold_buf_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_nx_s;
      pc_r       <= pc_nx_s;
      hold_buf_r <= hold_buf_nx_s;
    end
  end

  // Next-state logic; a redirect overrides everything in every state.
  always_comb begin
    state_nx_s    = state_r;
    pc_nx_s       = pc_r;
    hold_buf_nx_s = hold_buf_r;
    avail_s       = 1'b0;
    avail_ins_s   = hold_buf_r;
    case (state_r)
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_nx_s       = redirect_pc;
          hold_buf_nx_s = 32'h0000_0000;
          // An ack this cycle closes the old request; otherwise its response must be drained.
          state_nx_s    = imem.imem_ack ? ST_FETCH : ST_DRAIN;
        end else if (imem.imem_ack) begin
          avail_s     = 1'b1;
          avail_ins_s = imem.imem_rdata;
          if (consume_s) begin
            pc_nx_s    = pc_plus4(pc_r);
            state_nx_s = ST_FETCH;
          end else begin
            hold_buf_nx_s = imem.imem_rdata;
            state_nx_s    = ST_HOLD;
          end
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_nx_s       = redirect_pc;
          hold_buf_nx_s = 32'h0000_0000;
          state_nx_s    = ST_FETCH;
        end else begin
          avail_s     = 1'b1;
          avail_ins_s = hold_buf_r;
          if (consume_s) begin
            pc_nx_s    = pc_plus4(pc_r);
            state_nx_s = ST_FETCH;
          end else begin
            state_nx_s = ST_HOLD;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_nx_s       = redirect_pc;
          hold_buf_nx_s = 32'h0000_0000;
          state_nx_s    = ST_DRAIN;
        end else if (imem.imem_ack) begin
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_FETCH;
      end
    endcase
  end

  // IF/ID control: bubble on redirect or hazard stall, hold when IF/ID write is blocked.
  always_comb begin
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    if (redirect_valid || (Stall && PcWrite)) begin
      ifid_bubble_s = 1'b1;
    end else if (!IF_IDWrite) begin
      ifid_load_s = 1'b0;
    end else if (consume_s && avail_s) begin
      ifid_load_s = 1'b1;
    end else if (consume_s) begin
      ifid_bubble_s = 1'b1;
    end else begin
      ifid_load_s = 1'b0;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load_s),
    .bubble   (ifid_bubble_s),
    .ins      (avail_ins_s),
    .pc4      (pc_plus4(pc_r)),
    .id_ins   (IF_ID_ins),
    .id_pc4   (IF_ID_pc4),
    .id_valid (IF_ID_valid)
  );

  assign imem.imem_req  = (state_r == ST_FETCH);
  assign imem.imem_addr = pc_r;
  assign fetch_busy     = ((state_r == ST_FETCH) || (state_r == ST_DRAIN)) && !imem.imem_ack;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; each vector is one clock cycle.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        PcWrite;
  logic        IF_IDWrite;
  logic        Stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] IF_ID_ins;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;
  logic        fetch_busy;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PcWrite        (PcWrite),
    .IF_IDWrite     (IF_IDWrite),
    .Stall          (Stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .IF_ID_ins      (IF_ID_ins),
    .IF_ID_pc4      (IF_ID_pc4),
    .IF_ID_valid    (IF_ID_valid),
    .fetch_busy     (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];
  vec_t v;
  int   n_vec;
  int   n_miss;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      n_miss++;
    end
  endtask

  // One cycle: drive after the falling edge, check request side, then IF/ID after the rising edge.
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    PcWrite        = t.pw;
    IF_IDWrite     = t.iw;
    Stall          = t.st;
    redirect_valid = t.rv;
    redirect_pc    = t.rpc;
    imem.imem_ack   = t.ack;
    imem.imem_rdata = t.rdata;
    #1;
    chk("imem_req",   idx, {31'd0, imem.imem_req}, {31'd0, t.e_req});
    chk("imem_addr",  idx, imem.imem_addr, t.e_addr);
    chk("fetch_busy", idx, {31'd0, fetch_busy}, {31'd0, t.e_busy});
    @(posedge clk);
    #1;
    chk("IF_ID_ins",   idx, IF_ID_ins, t.e_ins);
    chk("IF_ID_pc4",   idx, IF_ID_pc4, t.e_pc4);
    chk("IF_ID_valid", idx, {31'd0, IF_ID_valid}, {31'd0, t.e_valid});
    n_vec++;
  endtask

  task automatic chk_reset_state(input int idx, input logic [31:0] exp_addr);
    chk("rst imem_req",    idx, {31'd0, imem.imem_req}, 32'd1);
    chk("rst imem_addr",   idx, imem.imem_addr, exp_addr);
    chk("rst fetch_busy",  idx, {31'd0, fetch_busy}, 32'd1);
    chk("rst IF_ID_ins",   idx, IF_ID_ins, 32'h0000_0000);
    chk("rst IF_ID_pc4",   idx, IF_ID_pc4, 32'h0000_0000);
    chk("rst IF_ID_valid", idx, {31'd0, IF_ID_valid}, 32'd0);
    n_vec++;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    //            pw    iw    st    rv    rpc            ack   rdata          req   addr           busy  ins            pc4            valid
    // zero-wait fetch with consume
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h1111_0000, 32'h0000_0004, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0004, 1'b1, 32'h0000_0004, 1'b0, 32'h1111_0004, 32'h0000_0008, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0008, 1'b1, 32'h0000_0008, 1'b0, 32'h1111_0008, 32'h0000_000C, 1'b1};
    // three-cycle ack latency
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000, 32'h0000_000C, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000, 32'h0000_000C, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h2222_000C, 1'b1, 32'h0000_000C, 1'b0, 32'h2222_000C, 32'h0000_0010, 1'b1};
    // ack while writes blocked -> HOLD, then consume
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h3333_0010, 1'b1, 32'h0000_0010, 1'b0, 32'h2222_000C, 32'h0000_0010, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0010, 1'b0, 32'h2222_000C, 32'h0000_0010, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0010, 1'b0, 32'h3333_0010, 32'h0000_0014, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0014, 1'b1, 32'h0000_0000, 32'h0000_0014, 1'b0};
    // redirect while awaiting ack -> DRAIN, late ack dropped
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 1'b1, 32'h0000_0000, 32'h0000_0014, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0040, 1'b1, 32'h0000_0000, 32'h0000_0014, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0040, 1'b0, 32'h0000_0000, 32'h0000_0014, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4444_0040, 1'b1, 32'h0000_0040, 1'b0, 32'h4444_0040, 32'h0000_0044, 1'b1};
    // Stall with PcWrite -> bubble, PC frozen
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0044, 1'b1, 32'h0000_0000, 32'h0000_0044, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h5555_0044, 1'b1, 32'h0000_0044, 1'b0, 32'h5555_0044, 32'h0000_0048, 1'b1};
    // redirect with same-cycle ack, then PC wrap
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hBAD0_BAD0, 1'b1, 32'h0000_0048, 1'b0, 32'h0000_0000, 32'h0000_0048, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h6666_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h6666_FFFC, 32'h0000_0000, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    // load-use freeze with ack completing into HOLD
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h7777_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'h7777_0000, 32'h0000_0004, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8888_0004, 1'b1, 32'h0000_0004, 1'b0, 32'h7777_0000, 32'h0000_0004, 1'b1};
    // redirect out of HOLD, then build up a HOLD with a valid IF/ID
    vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0,         1'b0, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h9999_0080, 1'b1, 32'h0000_0080, 1'b0, 32'h9999_0080, 32'h0000_0084, 1'b1};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hAAAA_0084, 1'b1, 32'h0000_0084, 1'b0, 32'h9999_0080, 32'h0000_0084, 1'b1};

    rst_n           = 1'b0;
    PcWrite         = 1'b0;
    IF_IDWrite      = 1'b0;
    Stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state(-1, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // Asynchronous reset in the middle of a HOLD cycle.
    @(negedge clk);
    PcWrite       = 1'b0;
    IF_IDWrite    = 1'b0;
    imem.imem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state(100, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk_reset_state(101, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // First request after reset presents RESET_PC.
    v = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCCCC_0000, 1'b1, 32'h0000_0000, 1'b0, 32'hCCCC_0000, 32'h0000_0004, 1'b1};
    apply(v, 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
